// File: rtl/pep_mmacc_body_rd_req.sv
// Body RAM read requester: queues pid commands, issues parity-tagged reads and forwards
// returned coefficients tagged with their pid. Optional stall counter: PEP_MMACC_BODY_RD_STALL_CNT_EN.
module pep_mmacc_body_rd_req #(
    parameter int unsigned PID_W      = 4,
    parameter int unsigned LWE_COEF_W = 12,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    input  logic                  i_reset_cache,
    input  logic [PID_W-1:0]      i_cmd_pid,
    input  logic                  i_cmd_vld,
    output logic                  o_cmd_rdy,
    output logic [PID_W-1:0]      o_boram_rd_pid,
    output logic                  o_boram_rd_vld,
    input  logic                  i_boram_rd_rdy,
    output logic                  o_boram_rd_parity,
    input  logic [LWE_COEF_W-1:0] i_boram_sxt_data,
    input  logic                  i_boram_sxt_data_vld,
    output logic                  o_boram_sxt_data_rdy,
    output logic [LWE_COEF_W-1:0] o_out_data,
    output logic [PID_W-1:0]      o_out_pid,
    output logic                  o_out_vld,
    input  logic                  i_out_rdy,
    output logic [3:0]            o_outst_cnt,
    output logic                  o_err_unexp,
    output logic [31:0]           o_stall_cnt
);

    localparam int unsigned FIFO_AW = $clog2(CMD_DEPTH);
    localparam int unsigned TAG_AW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned NB_PID  = 2 ** PID_W;
    localparam logic [FIFO_AW:0]  FIFO_FULL = (FIFO_AW + 1)'(CMD_DEPTH);
    localparam logic [3:0]        OUTST_MAX = 4'(MAX_OUTST);
    localparam logic [TAG_AW-1:0] TAG_LAST  = TAG_AW'(MAX_OUTST - 1);

    function automatic logic [TAG_AW-1:0] tag_inc(input logic [TAG_AW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [PID_W-1:0]      r_fifo_mem [CMD_DEPTH];
    logic [FIFO_AW-1:0]    r_fifo_wptr;
    logic [FIFO_AW-1:0]    r_fifo_rptr;
    logic [FIFO_AW:0]      r_fifo_cnt;
    logic [NB_PID-1:0]     r_par;
    logic [PID_W-1:0]      r_tag_mem [MAX_OUTST];
    logic [TAG_AW-1:0]     r_tag_wptr;
    logic [TAG_AW-1:0]     r_tag_rptr;
    logic [TAG_AW-1:0]     r_tag_dptr;
    logic [3:0]            r_outst_cnt;
    logic [LWE_COEF_W-1:0] r_out_data;
    logic [PID_W-1:0]      r_out_pid;
    logic                  r_out_vld;
    logic                  r_err_unexp;

    logic             w_cmd_rdy;
    logic             w_cmd_push;
    logic             w_rd_vld;
    logic             w_rd_hs;
    logic [PID_W-1:0] w_rd_pid;
    logic             w_sxt_rdy;
    logic             w_sxt_hs;
    logic             w_tag_avail;
    logic             w_data_ok;
    logic             w_out_hs;

    assign w_cmd_rdy  = !i_s_rst && (r_fifo_cnt != FIFO_FULL);
    assign w_cmd_push = i_cmd_vld && w_cmd_rdy;
    assign w_rd_vld   = !i_s_rst && (r_fifo_cnt != '0) && (r_outst_cnt < OUTST_MAX);
    assign w_rd_hs    = w_rd_vld && i_boram_rd_rdy;
    assign w_rd_pid   = r_fifo_mem[r_fifo_rptr];
    assign w_sxt_rdy  = !i_s_rst && (!r_out_vld || i_out_rdy);
    assign w_sxt_hs   = i_boram_sxt_data_vld && w_sxt_rdy;
    // The tag held by the output register is still queued, so data needs one beyond it.
    assign w_tag_avail = r_outst_cnt > {3'b000, r_out_vld};
    assign w_data_ok   = w_sxt_hs && w_tag_avail;
    assign w_out_hs    = r_out_vld && i_out_rdy;

    always_ff @(posedge i_clk) begin
        if (w_cmd_push) begin
            r_fifo_mem[r_fifo_wptr] <= i_cmd_pid;
        end
        if (w_rd_hs) begin
            r_tag_mem[r_tag_wptr] <= w_rd_pid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_cmd_push) r_fifo_wptr <= r_fifo_wptr + 1'b1;
            if (w_rd_hs)    r_fifo_rptr <= r_fifo_rptr + 1'b1;
            if (w_cmd_push && !w_rd_hs) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (!w_cmd_push && w_rd_hs) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
        end
    end

    // Clearing wins over a same-cycle toggle; the request already carries its parity.
    always_ff @(posedge i_clk) begin
        if (i_s_rst || i_reset_cache) begin
            r_par <= '0;
        end else if (w_rd_hs) begin
            r_par[w_rd_pid] <= !r_par[w_rd_pid];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_tag_wptr  <= '0;
            r_tag_rptr  <= '0;
            r_tag_dptr  <= '0;
            r_outst_cnt <= '0;
        end else begin
            if (w_rd_hs)   r_tag_wptr <= tag_inc(r_tag_wptr);
            if (w_out_hs)  r_tag_rptr <= tag_inc(r_tag_rptr);
            if (w_data_ok) r_tag_dptr <= tag_inc(r_tag_dptr);
            if (w_rd_hs && !w_out_hs) begin
                r_outst_cnt <= r_outst_cnt + 1'b1;
            end else if (!w_rd_hs && w_out_hs) begin
                r_outst_cnt <= r_outst_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_out_data  <= '0;
            r_out_pid   <= '0;
            r_out_vld   <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            if (w_data_ok) begin
                r_out_data <= i_boram_sxt_data;
                r_out_pid  <= r_tag_mem[r_tag_dptr];
                r_out_vld  <= 1'b1;
            end else if (i_out_rdy) begin
                r_out_vld <= 1'b0;
            end
            if (w_sxt_hs && !w_tag_avail) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

`ifdef PEP_MMACC_BODY_RD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_stall_cnt <= '0;
        end else if (w_rd_vld && !i_boram_rd_rdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    assign o_cmd_rdy            = w_cmd_rdy;
    assign o_boram_rd_pid       = w_rd_pid;
    assign o_boram_rd_vld       = w_rd_vld;
    assign o_boram_rd_parity    = r_par[w_rd_pid];
    assign o_boram_sxt_data_rdy = w_sxt_rdy;
    assign o_out_data           = r_out_data;
    assign o_out_pid            = r_out_pid;
    assign o_out_vld            = r_out_vld;
    assign o_outst_cnt          = r_outst_cnt;
    assign o_err_unexp          = r_err_unexp;

endmodule

// File: doc/pep_mmacc_body_rd_req.md
Name: pep_mmacc_body_rd_req

Overview:
- Read-side requester and consumer for the mmacc body RAM.
- Accepts per-PBS body read commands (pid) from mmacc control and issues boram_rd_pid/vld/parity requests, tracking the parity each pid expects on every read.
- Receives the mod-switched body coefficient stream (boram_sxt_data) and forwards each coefficient tagged with its pid to the sample-extract path.

Parameters:
- PID_W, 4, pid width; the per-pid parity array has 2**PID_W entries.
- LWE_COEF_W, 12, width of a mod-switched body coefficient.
- CMD_DEPTH, 4, command FIFO depth (power of 2, ≥2).
- MAX_OUTST, 2, maximum reads issued whose data has not yet left the output register (1..8).

Ports:
- clk  in  1  clock.
- s_rst  in  1  synchronous reset, active-high.
- reset_cache  in  1  single-cycle pulse that clears the parity array.
- cmd_pid  in  PID_W  pid to read.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command FIFO not full.
- boram_rd_pid  out  PID_W  read pid.
- boram_rd_vld  out  1  read request valid.
- boram_rd_rdy  in  1  body RAM accepts the request.
- boram_rd_parity  out  1  expected parity for boram_rd_pid.
- boram_sxt_data  in  LWE_COEF_W  returned coefficient.
- boram_sxt_data_vld  in  1  returned data valid.
- boram_sxt_data_rdy  out  1  ready for returned data.
- out_data  out  LWE_COEF_W  coefficient to sample extract.
- out_pid  out  PID_W  pid tag of out_data.
- out_vld  out  1  output valid.
- out_rdy  in  1  downstream ready.
- outst_cnt  out  4  current outstanding count.
- err_unexp  out  1  sticky flag: data returned with no outstanding tag.
- stall_cnt  out  32  read-stall cycle counter (optional feature).

Behaviour:
- Reset (s_rst=1), outputs: cmd_rdy=0 during reset, then 1. boram_rd_vld=0, out_vld=0, boram_sxt_data_rdy=0 during reset. outst_cnt=0, err_unexp=0, stall_cnt=0.
- Reset, state: FIFO emptied, tag queue emptied, parity array all 0. A reset mid-operation drops all in-flight tags; data arriving later sets err_unexp.
- Command FIFO: registered, CMD_DEPTH entries. Push on cmd_vld&cmd_rdy. cmd_rdy = !full.
  - Full: cmd_rdy=0.
  - Simultaneous push and pop when full: push is refused, because cmd_rdy is computed from the registered count.
  - Empty: boram_rd_vld=0.
- Command latency: a command pushed at cycle N can appear on boram_rd_vld at N+1 at the earliest.
- Issue: boram_rd_vld = !fifo_empty && outst_cnt<MAX_OUTST. boram_rd_pid = FIFO head.
  - boram_rd_vld, once high, stays high with stable pid/parity until boram_rd_rdy.
  - This holds because outst_cnt only decreases while a request is pending.
- Parity: boram_rd_parity = par[boram_rd_pid]. par[pid] toggles on the rd handshake.
  - reset_cache clears all par to 0 and takes priority over a same-cycle toggle; the in-flight request keeps the parity it presented.
- Tag queue: depth MAX_OUTST. Push pid on rd handshake; pop on output handshake.
  - outst_cnt = tag queue occupancy. It is +1 on issue, -1 on out handshake, unchanged when both occur in the same cycle.
- Data path: a single output register.
  - boram_sxt_data_rdy = !out_vld || out_rdy.
  - On data handshake, out_data and out_pid (tag queue head) are captured and out_vld=1 the next cycle; latency is 1 cycle.
  - out_vld/out_data/out_pid hold stable until out_rdy. Back-to-back throughput is 1 per cycle when out_rdy=1.
- Unexpected data: a data handshake while the tag queue is empty sets err_unexp=1 (sticky until s_rst), the data is discarded, and out_vld is not set.
- Pids are issued strictly in command order. Duplicate pids in the FIFO are allowed and receive alternating parity.

Optional Feature:
- Macro: PEP_MMACC_BODY_RD_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle with boram_rd_vld=1 && boram_rd_rdy=0. It saturates at 2**32-1 and clears on s_rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Pids 3,5 commanded, boram_rd_rdy=1, data 0x0A1/0x0B2 returned after 3 cycles each.
  - Required: boram_rd_parity 0,0; out (pid3,0x0A1) then (pid5,0x0B2); outst_cnt returns to 0.
- Pid 7 commanded 3 times.
  - Required: parity sequence 0,1,0; par[7]=1 at the end.
- MAX_OUTST=2, 4 commands queued, no data returned.
  - Required: exactly 2 rd handshakes; boram_rd_vld=0 while outst_cnt=2; a 3rd request issues only after an out handshake.
- out_rdy=0 for 5 cycles with 2 returns pending.
  - Required: out_vld held with stable data/pid; boram_sxt_data_rdy=0; no data lost after out_rdy=1.
- reset_cache pulsed in the same cycle as the rd handshake of pid 2 (par[2]=1).
  - Required: request carries parity 1; par[2]=0 afterwards; next read of pid 2 has parity 0.
- Data injected with an empty tag queue.
  - Required: err_unexp=1 the next cycle; out_vld stays 0.
- With the macro defined, boram_rd_rdy held 0 for 10 cycles while boram_rd_vld=1.
  - Required: stall_cnt=10.
